shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 118 +++++++++++
 tb/tb_shift_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one combinational shifter.
// Requests are granted round-robin on ties. Each accepted result lands
// in a single-entry output register, which can be drained and reloaded
// in the same cycle.
module shift_arbiter #(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_h,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_h,
  output logic [31:0] sh_a,
  output logic [31:0] sh_b,
  output logic [1:0]  sh_h,
  input  logic [31:0] sh_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic        any_valid;
  logic        grant;
  logic        can_accept;
  logic        accept;
  logic [31:0] rsp_data_q;
  logic        rsp_id_q;

  // Pick a winner: a lone requester wins; on a tie the port that did not win last time goes
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Accept when the buffer is free or being drained this cycle; reset blocks any handshake
  always_comb begin
    can_accept = ~rst & ((state == EMPTY) | rsp_ready);
    accept     = can_accept & any_valid;
    req0_ready = accept & ~grant;
    req1_ready = accept & grant;
  end

  // Steer the winner's operands to the shared shifter, zeros when nobody is asking
  always_comb begin
    sh_a = '0;
    sh_b = '0;
    sh_h = '0;
    if (any_valid) begin
      if (grant) begin
        sh_a = req1_a;
        sh_b = req1_b;
        sh_h = req1_h;
      end else begin
        sh_a = req0_a;
        sh_b = req0_b;
        sh_h = req0_h;
      end
    end
  end

  // Output buffer occupancy: a new accept always fills, otherwise a drain empties
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = FULL;
    end else if (rsp_ready) begin
      state_next = EMPTY;
    end
  end

  // Occupancy register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Capture the shifter result and remember who won, but only on a real handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      last_grant <= ~PRIO_RESET;
    end else if (accept) begin
      rsp_data_q <= sh_result;
      rsp_id_q   <= grant;
      last_grant <= grant;
    end
  end

  assign rsp_valid = (state == FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scoreboard bench for shift_arbiter with a behavioural
// reference model and an environment-side combinational shifter.
module tb_shift_arbiter;

  localparam bit PRIO = 1'b0;

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  h;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        id;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]  req0_h = '0, req1_h = '0;
  logic [31:0] sh_a, sh_b, sh_result;
  logic [1:0]  sh_h;
  logic        rsp_valid, rsp_id;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;

  rsp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_full = 1'b0;
  bit   m_last = !PRIO;
  bit   pushed_now = 1'b0;
  bit   flush = 1'b0;
  bit   mon_en = 1'b0;
  bit   after_rst = 1'b0;
  bit   acc[2];
  req_t none = '{1'b0, 32'd0, 32'd0, 2'd0};
  req_t pend[2];

  shift_arbiter #(.PRIO_RESET(PRIO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_h(req0_h),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_h(req1_h),
    .sh_a(sh_a), .sh_b(sh_b), .sh_h(sh_h), .sh_result(sh_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  // Shared shifter living outside the arbiter
  always_comb begin
    case (sh_h)
      2'b00:   sh_result = sh_a << sh_b[4:0];
      2'b01:   sh_result = sh_a >> sh_b[4:0];
      default: sh_result = 32'($signed(sh_a) >>> sh_b[4:0]);
    endcase
  end

  // Reference shift computed by multiplication/division by a power of two
  function automatic logic [31:0] refShift(logic [31:0] a, logic [31:0] b, logic [1:0] h);
    longint p;
    longint v;
    longint q;
    longint unsigned prod;
    p = 1;
    for (int i = 0; i < int'(b % 32); i++) p = p * 2;
    if (h == 2'b00) begin
      prod = 64'(a) * 64'(p);
      return prod[31:0];
    end else if (h == 2'b01 || a[31] == 1'b0) begin
      q = longint'(a) / p;
      return 32'(q);
    end else begin
      v = longint'(a) - 64'sd4294967296;
      q = v / p;
      if (v % p != 0) q = q - 1;
      return 32'(q);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict readies, grant and shifter operands from the arbitration rules; queue expected results
  task automatic checkOutput();
    bit          can, any, g;
    logic [31:0] ea, eb;
    logic [1:0]  eh;
    can = !rst && (!m_full || rsp_ready);
    any = req0_valid || req1_valid;
    g   = (req0_valid && req1_valid) ? !m_last : req1_valid;
    check("req_ready", {30'd0, req1_ready, req0_ready},
          {30'd0, can && any && g, can && any && !g});
    if (after_rst) begin
      check("rst_data", rsp_data, 32'd0);
      check("rst_id", {31'd0, rsp_id}, 32'd0);
      check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    end
    after_rst  = 1'b0;
    acc[0]     = 1'b0;
    acc[1]     = 1'b0;
    pushed_now = 1'b0;
    if (rst) begin
      m_full    = 1'b0;
      m_last    = !PRIO;
      flush     = 1'b1;
      after_rst = 1'b1;
    end else if (can && any) begin
      ea = g ? req1_a : req0_a;
      eb = g ? req1_b : req0_b;
      eh = g ? req1_h : req0_h;
      check("sh_a", sh_a, ea);
      check("sh_b", sh_b, eb);
      check("sh_h", {30'd0, sh_h}, {30'd0, eh});
      sbq.push_back('{refShift(ea, eb, eh), g});
      m_last     = g;
      m_full     = 1'b1;
      pushed_now = 1'b1;
      acc[g]     = 1'b1;
    end else begin
      if (!any) check("sh_idle", sh_a | sh_b | {30'd0, sh_h}, 32'd0);
      if (rsp_ready) m_full = 1'b0;
    end
  endtask

  // Drive one cycle of inputs shortly after the rising edge, then check and wait for the next edge
  task automatic applyStimulus(input bit r, input req_t p0, input req_t p1, input bit rr);
    #1;
    if (flush) begin
      sbq.delete();
      flush = 1'b0;
    end
    rst        = r;
    req0_valid = p0.v;
    req0_a     = p0.a;
    req0_b     = p0.b;
    req0_h     = p0.h;
    req1_valid = p1.v;
    req1_a     = p1.a;
    req1_b     = p1.b;
    req1_h     = p1.h;
    rsp_ready  = rr;
    #1;
    checkOutput();
    @(posedge clk);
  endtask

  // Random requesters that hold each request until it is accepted, followed by a drain
  task automatic runRandom(input int n, input int vpct, input int rpct, input int rstpct);
    bit r, rr, gen;
    pend[0] = none;
    pend[1] = none;
    acc[0]  = 1'b0;
    acc[1]  = 1'b0;
    for (int c = 0; c < n + 40; c++) begin
      gen = (c < n);
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) pend[k].v = 1'b0;
        if (gen && !pend[k].v && $urandom_range(99) < vpct)
          pend[k] = '{1'b1, $urandom, $urandom, 2'($urandom)};
      end
      if (!gen && !pend[0].v && !pend[1].v) break;
      r  = gen && ($urandom_range(99) < rstpct);
      rr = !gen || ($urandom_range(99) < rpct);
      applyStimulus(r, pend[0], pend[1], rr);
    end
  endtask

  // Monitor: compare the presented result with the oldest expectation, pop on consumption
  always @(negedge clk) begin
    if (mon_en) begin
      bit ev;
      ev = sbq.size() > (pushed_now ? 1 : 0);
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
      if (rsp_valid && ev) begin
        check("rsp_data", rsp_data, sbq[0].data);
        check("rsp_id", {31'd0, rsp_id}, {31'd0, sbq[0].id});
        if (rsp_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    req_t a, b;
    @(posedge clk);
    applyStimulus(1'b1, none, none, 1'b0);
    applyStimulus(1'b1, none, none, 1'b1);
    mon_en = 1'b1;

    // Single request: 1 << 4
    $display("[TB] single request");
    applyStimulus(1'b0, '{1'b1, 32'h1, 32'd4, 2'b00}, none, 1'b1);
    applyStimulus(1'b0, none, none, 1'b1);
    applyStimulus(1'b0, none, none, 1'b1);

    // Tie right after reset: port 0 first, then port 1
    $display("[TB] tie after reset");
    applyStimulus(1'b1, none, none, 1'b1);
    a = '{1'b1, 32'h8000_0000, 32'd31, 2'b01};
    b = '{1'b1, 32'h8000_0000, 32'd4, 2'b10};
    applyStimulus(1'b0, a, b, 1'b1);
    applyStimulus(1'b0, none, b, 1'b1);
    applyStimulus(1'b0, none, none, 1'b1);
    applyStimulus(1'b0, none, none, 1'b1);

    // Backpressure for three cycles with both ports asking
    $display("[TB] backpressure");
    applyStimulus(1'b0, '{1'b1, 32'hA5A5_0001, 32'd3, 2'b00}, none, 1'b0);
    a = '{1'b1, 32'h0F0F_0000, 32'd8, 2'b01};
    b = '{1'b1, 32'hF000_0000, 32'd2, 2'b11};
    repeat (3) applyStimulus(1'b0, a, b, 1'b0);
    applyStimulus(1'b0, a, b, 1'b1);
    applyStimulus(1'b0, a, none, 1'b1);
    applyStimulus(1'b0, none, none, 1'b1);
    applyStimulus(1'b0, none, none, 1'b1);

    // Streaming with both ports always busy
    $display("[TB] streaming");
    runRandom(8, 100, 100, 0);

    // Shift amount uses only the low five bits
    $display("[TB] amount masking");
    applyStimulus(1'b0, none, '{1'b1, 32'h4, 32'h21, 2'b01}, 1'b1);
    applyStimulus(1'b0, none, none, 1'b1);
    applyStimulus(1'b0, none, none, 1'b1);

    // Reset while a result is pending, with both ports requesting during reset
    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, '{1'b1, 32'h1234_5678, 32'd0, 2'b00}, none, 1'b0);
    applyStimulus(1'b0, none, none, 1'b0);
    applyStimulus(1'b1, '{1'b1, 32'h1, 32'd1, 2'b00}, '{1'b1, 32'h2, 32'd2, 2'b00}, 1'b1);
    applyStimulus(1'b0, none, none, 1'b1);
    applyStimulus(1'b0, none, none, 1'b1);

    // Long random run with occasional resets
    $display("[TB] random traffic");
    runRandom(600, 60, 70, 2);

    repeat (3) applyStimulus(1'b0, none, none, 1'b1);
    check("drained", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
